// File: rtl/cla_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cla_serial_adder_ctrl
// Function : WIDTH-bit adder built from one 4-bit carry-lookahead slice,
//            one nibble per clock (LSB first), with a start/busy/done handshake.
//            Optional macro CLA_SERIAL_SUB_EN adds a 'sub' input (a - b).
// Revision : 1.0
// ============================================================================
module cla_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int              NIB      = WIDTH / 4;
  localparam int              IDXW     = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;

  logic [3:0] nib_a, nib_b, p, g, c, s;

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int n = 0; n < NIB; n++) begin
      if (idx_q == IDXW'(n)) begin
        nib_a = a_q[4*n +: 4];
        nib_b = b_q[4*n +: 4];
      end
    end
  end

  // Fully expanded lookahead carries: each depends only on p/g and carry_q.
  assign p    = nib_a | nib_b;
  assign g    = nib_a & nib_b;
  assign c[0] = g[0] | (p[0] & carry_q);
  assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
  assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & carry_q);
  assign c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & carry_q);
  assign s    = nib_a ^ nib_b ^ {c[2:0], carry_q};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
`ifdef CLA_SERIAL_SUB_EN
          if (sub) begin
            b_d     = ~b;
            carry_d = 1'b1;
          end
`endif
          idx_d   = '0;
          sum_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int n = 0; n < NIB; n++) begin
          if (idx_q == IDXW'(n)) sum_d[4*n +: 4] = s;
        end
        carry_d = c[3];
        if (idx_q == LAST_IDX) begin
          cout_d  = c[3];
          ovf_d   = c[2] ^ c[3];
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_serial_adder_ctrl.sv
`default_nettype none
// Testbench for cla_serial_adder_ctrl: WIDTH=16 and WIDTH=4 instances checked
// against an integer-arithmetic reference model.
module tb_cla_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, cin, busy, done, cout, ovf;
  logic [15:0] a, b, sum;
`ifdef CLA_SERIAL_SUB_EN
  logic        sub;
`endif
  logic        start4, cin4, busy4, done4, cout4, ovf4;
  logic [3:0]  a4, b4, sum4;

  int checks = 0;
  int errors = 0;

  cla_serial_adder_ctrl #(.WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef CLA_SERIAL_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  cla_serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
`ifdef CLA_SERIAL_SUB_EN
    .sub(1'b0),
`endif
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  // Returns {ovf, cout, sum} computed with plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic do_sub);
    int r, sr;
    if (!do_sub) begin
      r  = int'(x) + int'(y) + int'(ci);
      sr = int'($signed(x)) + int'($signed(y)) + int'(ci);
    end else begin
      r  = int'(x) - int'(y) + 65536;
      sr = int'($signed(x)) - int'($signed(y));
    end
    return {(sr > 32767 || sr < -32768), (r >= 65536), r[15:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one operation, scrambles inputs after acceptance, waits for done.
  task automatic launch(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                        output int lat, output int busy_cnt,
                        output logic [17:0] res, output logic done_after);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    tick();
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    lat = 0; busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    res = {ovf, cout, sum};
    tick();
    done_after = done;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; start4 = 1'b0;
    a = '0; b = '0; cin = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
`ifdef CLA_SERIAL_SUB_EN
    sub = 1'b0;
`endif
    tick(); tick();
    checks++;
    if ({busy, done, sum, cout, ovf} !== 20'h0) begin
      errors++;
      $display("FAIL reset16: got %h want 0", {busy, done, sum, cout, ovf});
    end
    checks++;
    if ({busy4, done4, sum4, cout4, ovf4} !== 8'h0) begin
      errors++;
      $display("FAIL reset4: got %h want 0", {busy4, done4, sum4, cout4, ovf4});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    int lat, bc; logic [17:0] res; logic da;
    launch(16'h1234, 16'h4321, 1'b0, lat, bc, res, da);
    checks++;
    if (res !== {1'b0, 1'b0, 16'h5555}) begin
      errors++; $display("FAIL basic_result: got %h want %h", res, {2'b00, 16'h5555});
    end
    checks++;
    if (lat != 4 || bc != 4 || da !== 1'b0) begin
      errors++; $display("FAIL basic_timing: lat=%0d busy=%0d done_after=%b want 4 4 0", lat, bc, da);
    end
    checks++;
    if (sum !== 16'h5555) begin
      errors++; $display("FAIL basic_hold: got %h want 5555", sum);
    end
  endtask

  task automatic test_carry_chain;
    int lat, bc; logic [17:0] res; logic da;
    launch(16'hFFFF, 16'h0001, 1'b0, lat, bc, res, da);
    checks++;
    if (res !== {1'b0, 1'b1, 16'h0000}) begin
      errors++; $display("FAIL carry_ffff: got %h want %h", res, {2'b01, 16'h0000});
    end
    launch(16'h7FFF, 16'h0000, 1'b1, lat, bc, res, da);
    checks++;
    if (res !== {1'b1, 1'b0, 16'h8000}) begin
      errors++; $display("FAIL carry_7fff: got %h want %h", res, {2'b10, 16'h8000});
    end
  endtask

  task automatic test_random;
    int lat, bc; logic [17:0] res, exp; logic da;
    logic [15:0] x, y; logic ci;
    for (int i = 0; i < 25; i++) begin
      x = 16'($urandom); y = 16'($urandom); ci = 1'($urandom);
      if (i == 0) begin x = 16'h8000; y = 16'h8000; end
      exp = model(x, y, ci, 1'b0);
      launch(x, y, ci, lat, bc, res, da);
      checks++;
      if (res !== exp || lat != 4) begin
        errors++;
        $display("FAIL random_add %h+%h+%b: got %h lat %0d want %h lat 4", x, y, ci, res, lat, exp);
      end
    end
  endtask

  task automatic test_busy_reject;
    int pulses; logic [15:0] got;
    pulses = 0; got = '0;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 16'h0001; b = 16'h0001; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin pulses++; got = sum; end
      tick();
    end
    checks++;
    if (pulses != 1 || got !== 16'h3333) begin
      errors++; $display("FAIL busy_reject: pulses=%0d sum=%h want 1 3333", pulses, got);
    end
    checks++;
    if (sum !== 16'h3333 || busy !== 1'b0) begin
      errors++; $display("FAIL busy_reject_hold: sum=%h busy=%b want 3333 0", sum, busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] xs [4]; logic [15:0] ys [4]; logic [17:0] exp;
    int k, cyc, last;
    for (int i = 0; i < 4; i++) begin xs[i] = 16'($urandom); ys[i] = 16'($urandom); end
    k = 0; cyc = 0; last = -1;
    a = xs[0]; b = ys[0]; cin = 1'b0; start = 1'b1;
    while (k < 4 && cyc < 60) begin
      tick();
      cyc++;
      if (done) begin
        exp = model(xs[k], ys[k], 1'b0, 1'b0);
        checks++;
        if ({ovf, cout, sum} !== exp) begin
          errors++; $display("FAIL b2b_result[%0d]: got %h want %h", k, {ovf, cout, sum}, exp);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 6) begin
            errors++; $display("FAIL b2b_period[%0d]: got %0d want 6", k, cyc - last);
          end
        end
        last = cyc;
        k++;
        if (k < 4) begin a = xs[k]; b = ys[k]; end
        else start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (k != 4) begin
      errors++; $display("FAIL b2b_count: got %0d results want 4", k);
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid;
    int pulses, lat, bc; logic [17:0] res, exp; logic da; logic [15:0] x, y;
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, sum, cout, ovf} !== 20'h0) begin
      errors++; $display("FAIL reset_mid: got %h want 0", {busy, done, sum, cout, ovf});
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) pulses++;
      tick();
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL reset_mid_quiet: got %0d active cycles want 0", pulses);
    end
    x = 16'($urandom); y = 16'($urandom);
    exp = model(x, y, 1'b1, 1'b0);
    launch(x, y, 1'b1, lat, bc, res, da);
    checks++;
    if (res !== exp || lat != 4) begin
      errors++; $display("FAIL reset_mid_fresh: got %h lat %0d want %h lat 4", res, lat, exp);
    end
  endtask

`ifdef CLA_SERIAL_SUB_EN
  task automatic test_sub;
    int lat, bc; logic [17:0] res, exp; logic da; logic [15:0] x, y;
    sub = 1'b1;
    launch(16'h0005, 16'h0007, 1'b0, lat, bc, res, da);
    checks++;
    if (res !== {1'b0, 1'b0, 16'hFFFE}) begin
      errors++; $display("FAIL sub_5_7: got %h want %h", res, {2'b00, 16'hFFFE});
    end
    launch(16'h8000, 16'h0001, 1'b0, lat, bc, res, da);
    checks++;
    if (res !== {1'b1, 1'b1, 16'h7FFF}) begin
      errors++; $display("FAIL sub_8000_1: got %h want %h", res, {2'b11, 16'h7FFF});
    end
    for (int i = 0; i < 10; i++) begin
      x = 16'($urandom); y = 16'($urandom);
      exp = model(x, y, 1'b0, 1'b1);
      launch(x, y, 1'($urandom), lat, bc, res, da);
      checks++;
      if (res !== exp) begin
        errors++; $display("FAIL sub_random %h-%h: got %h want %h", x, y, res, exp);
      end
    end
    sub = 1'b0;
  endtask
`endif

  task automatic test_width4;
    int lat, r, sr; logic [3:0] x, y; logic ci; logic [5:0] exp;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin x = 4'h9; y = 4'h8; ci = 1'b1; end
      else begin x = 4'($urandom); y = 4'($urandom); ci = 1'($urandom); end
      r   = int'(x) + int'(y) + int'(ci);
      sr  = int'($signed(x)) + int'($signed(y)) + int'(ci);
      exp = {(sr > 7 || sr < -8), (r >= 16), 4'(r)};
      a4 = x; b4 = y; cin4 = ci; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom);
      lat = 0;
      while (!done4 && lat < 10) begin tick(); lat++; end
      checks++;
      if ({ovf4, cout4, sum4} !== exp || lat != 1) begin
        errors++;
        $display("FAIL width4 %h+%h+%b: got %h lat %0d want %h lat 1", x, y, ci, {ovf4, cout4, sum4}, lat, exp);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_chain();
    test_random();
    test_busy_reject();
    test_back_to_back();
    test_reset_mid();
`ifdef CLA_SERIAL_SUB_EN
    test_sub();
`endif
    test_width4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cla_serial_adder_ctrl.md
Name: cla_serial_adder_ctrl

Overview:
- Sequencer that reuses one 4-bit carry-lookahead slice to add WIDTH-bit operands, one nibble per clock, least significant nibble first.
- Registers the carry between nibbles and assembles the result.
- Provides a start/busy/done handshake to the requesting datapath.
- Trades latency for area in wide-add paths where a full-width lookahead adder is not justified.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, nibble count (derived; not to be overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepted start
- b  input  WIDTH  operand B; captured on the accepted start
- cin  input  1  carry-in; captured on the accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  result register
- cout  output  1  carry out of the MSB
- ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst. All state changes occur on the rising edge of clk.
- Reset: state=IDLE, nibble index=0, carry reg=0, operand regs=0, sum=0, cout=0, ovf=0, busy=0, done=0. Reset takes priority over every other event.
- Reset mid-RUN aborts the operation: no done pulse, all outputs cleared at that edge.
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1, load a/b into operand regs, load carry reg from cin, idx=0, clear sum, go to RUN. Otherwise hold state; sum, cout and ovf keep the last result.
- RUN, each edge:
  - Nibble idx of the operands plus the carry reg go through the 4-bit lookahead slice: per-bit p=a|b, g=a&b, ripple-free carries c[i]=g[i]|(p[i]&c[i-1]), sum bit=(a^b)^carry-in of that bit.
  - Write the 4 sum bits to sum[4*idx+3:4*idx] and the slice carry-out to the carry reg.
  - If idx=NIB-1: cout=slice carry-out, ovf=carry into bit 3 XOR slice carry-out, go to DONE. Otherwise idx=idx+1.
- DONE: done=1 for exactly this one cycle, busy=0, then go to IDLE unconditionally.
- Latency: start sampled at edge E0; done is high in the cycle after edge E0+NIB (WIDTH=16: 4 cycles). Throughput is one operation per NIB+2 cycles.
- start is ignored in RUN and DONE; it is not queued. A start held high through DONE is accepted on the first IDLE cycle.
- Changes to a, b or cin after acceptance have no effect on the operation in flight.
- sum holds a partial result while busy=1. Consumers sample sum, cout and ovf only on done or afterwards; these stay stable until the next accepted start.
- WIDTH=4: RUN lasts exactly one cycle.

Optional Feature:
- Macro: CLA_SERIAL_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), captured with the operands on the accepted start.
  - sub=1 stores ~b into the B operand reg and forces the carry reg to 1, ignoring cin; result is a-b, cout=1 means no borrow, ovf is signed-subtract overflow.
  - sub=0 gives the plain add behaviour.
- Undefined: no sub port; add only.

Test Plan:
- Basic add: WIDTH=16, a=0x1234, b=0x4321, cin=0, start for 1 cycle -> busy high 4 cycles, done pulse 1 cycle, sum=0x5555, cout=0, ovf=0.
- Full carry chain: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
- Busy rejection: start again 2 cycles into RUN with a=0x0001, b=0x0001 -> ignored, first result unchanged, exactly one done pulse. Start held high continuously -> back-to-back results, done period 6 cycles.
- Reset mid-operation: rst=1 on the 2nd RUN cycle -> next cycle busy=0, done=0, sum=0, cout=0, no done pulse. A fresh start then completes normally.
- Subtract (CLA_SERIAL_SUB_EN defined): a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- WIDTH=4 instance: a=0x9, b=0x8, cin=1 -> done after 1 RUN cycle, sum=0x2, cout=1, ovf=1.
